// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants, state type and framing helpers for the AES Avalon-ST
// transmit serializer.
//
// Contents:
//   BLOCK_W, ST_DATA_W, BEATS, EMPTY_W : datapath geometry
//   state_t                            : serializer FSM states (IDLE, SEND)
//   bytes_to_beats(bytes)              : beats needed for a final block
//   bytes_to_empty(bytes)              : empty field on the final beat
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int ST_DATA_W = 32;
    localparam int BEATS     = BLOCK_W / ST_DATA_W;
    localparam int EMPTY_W   = $clog2(ST_DATA_W / 8);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // A byte count of 0 stands for a full 16-byte block. The beat count is
    // ceil(bytes / 4) for the 32-bit beat width.
    function automatic logic [2:0] bytes_to_beats(input logic [3:0] bytes);
        logic [4:0] n;
        n = (bytes == 4'd0) ? 5'd16 : {1'b0, bytes};
        return 3'((n + 5'd3) >> 2);
    endfunction

    // Unused byte lanes in the last beat: (4 - bytes % 4) % 4, which is the
    // two's-complement negation of the count modulo 4.
    function automatic logic [1:0] bytes_to_empty(input logic [3:0] bytes);
        return 2'(4'd0 - bytes);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST streaming bundle with sop/eop/empty framing, ready latency 0.
//
// Signals:
//   data  [DATA_W-1:0]  : beat payload, first byte in the top byte lane
//   valid               : beat offered by the source
//   ready               : beat accepted by the sink when valid && ready
//   sop / eop           : first / last beat of a packet
//   empty [EMPTY_W-1:0] : unused byte lanes on the eop beat
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface avalon_st_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);

    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               ready;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;

    modport master (
        output data,
        output valid,
        input  ready,
        output sop,
        output eop,
        output empty
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        input  sop,
        input  eop,
        input  empty
    );

endinterface

// File: rtl/aes_st_serializer.sv
// -----------------------------------------------------------------------------
// aes_st_serializer
// Transmit side of the AES Avalon-ST stream. Takes 128-bit AES blocks over a
// valid/ready handshake and emits them as 32-bit Avalon-ST beats, most
// significant word first, with sop/eop/empty message framing. Messages may
// span several blocks; the final block may be partial.
//
// Ports:
//   clk        : clock
//   rst_n      : synchronous reset, active low
//   blk_data   : AES block, byte 0 in [127:120]
//   blk_valid  : block offered
//   blk_ready  : block accepted when blk_valid && blk_ready
//   blk_last   : block is the final block of its message
//   blk_bytes  : valid bytes in a final block, 0 meaning 16
//   data_out   : Avalon-ST source (data, valid, ready, sop, eop, empty)
// -----------------------------------------------------------------------------
module aes_st_serializer #(
    parameter int ST_DATA_W = aes_pkg::ST_DATA_W,
    parameter int BLOCK_W   = aes_pkg::BLOCK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLOCK_W-1:0] blk_data,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_last,
    input  logic [3:0]         blk_bytes,
    avalon_st_if.master        data_out
);

    import aes_pkg::*;

    localparam int NBEATS  = BLOCK_W / ST_DATA_W;
    localparam int EMPTY_B = $clog2(ST_DATA_W / 8);

    state_t               state_q,  state_d;
    logic [BLOCK_W-1:0]   blk_q,    blk_d;
    logic                 last_q,   last_d;
    logic [2:0]           nbeats_q, nbeats_d;
    logic [EMPTY_B-1:0]   empty_q,  empty_d;
    logic [2:0]           beat_q,   beat_d;
    logic                 in_msg_q, in_msg_d;

    logic                 sending;
    logic                 final_beat;
    logic                 beat_acc;
    logic                 blk_acc;
    logic                 sop_int;
    logic                 eop_int;
    logic [ST_DATA_W-1:0] beat_data;

    // Handshake decode. blk_ready opens on the final beat of a block only
    // when that beat is being taken, giving back-to-back blocks without a
    // bubble while never looking at blk_valid.
    always_comb begin
        sending    = (state_q == SEND);
        final_beat = sending && (beat_q == (nbeats_q - 3'd1));
        beat_acc   = sending && data_out.ready;
        blk_ready  = rst_n && ((state_q == IDLE) || (final_beat && data_out.ready));
        blk_acc    = blk_valid && blk_ready;
        sop_int    = (beat_q == 3'd0) && !in_msg_q;
        eop_int    = last_q && final_beat;
    end

    // Select the current word, most significant word first.
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (beat_q == 3'(i)) begin
                beat_data = blk_q[BLOCK_W-1-ST_DATA_W*i -: ST_DATA_W];
            end
        end
    end

    // Stream outputs are pure functions of the registered state, so they stay
    // put while the sink stalls. Everything is forced low while in reset.
    always_comb begin
        data_out.valid = rst_n && sending;
        data_out.data  = data_out.valid ? beat_data : '0;
        data_out.sop   = data_out.valid && sop_int;
        data_out.eop   = data_out.valid && eop_int;
        data_out.empty = (data_out.valid && eop_int) ? empty_q : '0;
    end

    // Next-state logic. A block load overrides the end-of-block return to
    // IDLE so a queued block starts on the very next cycle.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        last_d   = last_q;
        nbeats_d = nbeats_q;
        empty_d  = empty_q;
        beat_d   = beat_q;
        in_msg_d = in_msg_q;

        if (beat_acc) begin
            // sop and eop on the same beat leave the message closed.
            if (sop_int) begin
                in_msg_d = 1'b1;
            end
            if (eop_int) begin
                in_msg_d = 1'b0;
            end
            if (final_beat) begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end else begin
                beat_d = beat_q + 3'd1;
            end
        end

        if (blk_acc) begin
            state_d  = SEND;
            blk_d    = blk_data;
            last_d   = blk_last;
            nbeats_d = blk_last ? bytes_to_beats(blk_bytes) : 3'(NBEATS);
            empty_d  = blk_last ? EMPTY_B'(bytes_to_empty(blk_bytes)) : '0;
            beat_d   = 3'd0;
        end
    end

    // State registers. Reset drops any partial block without an eop and
    // clears in_msg so the next beat opens a new message with sop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            last_q   <= 1'b0;
            nbeats_q <= 3'd0;
            empty_q  <= '0;
            beat_q   <= 3'd0;
            in_msg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            last_q   <= last_d;
            nbeats_q <= nbeats_d;
            empty_q  <= empty_d;
            beat_q   <= beat_d;
            in_msg_q <= in_msg_d;
        end
    end

endmodule

// File: tb/tb_aes_st_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_st_serializer
// Directed bench for aes_st_serializer. Inputs change just after the falling
// edge and outputs are sampled 1 ns later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_aes_st_serializer;

    logic         clk;
    logic         rst_n;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;
    logic [3:0]   blk_bytes;

    int checkCount;
    int errorCount;

    avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) st_if ();

    aes_st_serializer #(
        .ST_DATA_W (32),
        .BLOCK_W   (128)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last),
        .blk_bytes (blk_bytes),
        .data_out  (st_if.master)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic last,
                                 input logic [3:0] bytes);
        blk_data  = data;
        blk_last  = last;
        blk_bytes = bytes;
        blk_valid = 1'b1;
    endtask

    task automatic expectBeat(input string tag, input logic [31:0] data,
                              input logic sop, input logic eop, input logic [1:0] empty);
        checkOutput({tag, ".valid"}, st_if.valid, 1'b1);
        checkOutput({tag, ".data"},  st_if.data,  data);
        checkOutput({tag, ".sop"},   st_if.sop,   sop);
        checkOutput({tag, ".eop"},   st_if.eop,   eop);
        checkOutput({tag, ".empty"}, st_if.empty, empty);
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h10000001_10000002_10000003_10000004;
    localparam logic [127:0] BLK_C = 128'h20000001_20000002_20000003_20000004;
    localparam logic [127:0] BLK_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    localparam logic [127:0] BLK_E = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;

    logic [31:0] wordsA [4];
    int          pat    [8];

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst_n       = 1'b0;
        blk_data    = '0;
        blk_valid   = 1'b0;
        blk_last    = 1'b0;
        blk_bytes   = 4'd0;
        st_if.ready = 1'b1;
        wordsA      = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        pat         = '{1, 0, 0, 1, 0, 1, 0, 1};

        // Reset values.
        tick(); tick(); settle();
        checkOutput("rst.blk_ready", blk_ready, 1'b0);
        checkOutput("rst.valid", st_if.valid, 1'b0);
        checkOutput("rst.sop", st_if.sop, 1'b0);
        checkOutput("rst.eop", st_if.eop, 1'b0);
        checkOutput("rst.empty", st_if.empty, 2'd0);
        checkOutput("rst.data", st_if.data, 32'd0);
        tick(); rst_n = 1'b1; settle();
        checkOutput("idle.blk_ready", blk_ready, 1'b1);
        checkOutput("idle.valid", st_if.valid, 1'b0);

        // Full single-block message.
        tick(); applyStimulus(BLK_A, 1'b1, 4'd0); settle();
        tick(); blk_valid = 1'b0; settle();
        expectBeat("full.b0", 32'h00112233, 1'b1, 1'b0, 2'd0);
        checkOutput("full.b0.blk_ready", blk_ready, 1'b0);
        tick(); settle(); expectBeat("full.b1", 32'h44556677, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("full.b2", 32'h8899AABB, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("full.b3", 32'hCCDDEEFF, 1'b0, 1'b1, 2'd0);
        checkOutput("full.b3.blk_ready", blk_ready, 1'b1);
        tick(); settle();
        checkOutput("full.after.valid", st_if.valid, 1'b0);

        // Partial final block of 5 bytes.
        tick(); applyStimulus(BLK_A, 1'b1, 4'd5);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("p5.b0", 32'h00112233, 1'b1, 1'b0, 2'd0);
        tick(); settle();
        expectBeat("p5.b1", 32'h44556677, 1'b0, 1'b1, 2'd3);
        checkOutput("p5.b1.blk_ready", blk_ready, 1'b1);
        tick(); settle();
        checkOutput("p5.after.valid", st_if.valid, 1'b0);

        // Partial final block of 10 bytes.
        tick(); applyStimulus(BLK_D, 1'b1, 4'd10);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("p10.b0", 32'hD0D1D2D3, 1'b1, 1'b0, 2'd0);
        tick(); settle(); expectBeat("p10.b1", 32'hD4D5D6D7, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("p10.b2", 32'hD8D9DADB, 1'b0, 1'b1, 2'd2);
        tick(); settle();
        checkOutput("p10.after.valid", st_if.valid, 1'b0);

        // Two-block message with blk_valid held high: 8 beats, no gap.
        tick(); applyStimulus(BLK_B, 1'b0, 4'd0);
        tick(); applyStimulus(BLK_C, 1'b1, 4'd0); settle();
        expectBeat("msg2.b0", 32'h10000001, 1'b1, 1'b0, 2'd0);
        checkOutput("msg2.b0.blk_ready", blk_ready, 1'b0);
        tick(); settle(); expectBeat("msg2.b1", 32'h10000002, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("msg2.b2", 32'h10000003, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("msg2.b3", 32'h10000004, 1'b0, 1'b0, 2'd0);
        checkOutput("msg2.b3.blk_ready", blk_ready, 1'b1);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("msg2.b4", 32'h20000001, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("msg2.b5", 32'h20000002, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("msg2.b6", 32'h20000003, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("msg2.b7", 32'h20000004, 1'b0, 1'b1, 2'd0);
        tick(); settle();
        checkOutput("msg2.after.valid", st_if.valid, 1'b0);

        // Single-beat messages back to back: each carries sop and eop.
        tick(); applyStimulus(BLK_D, 1'b1, 4'd4);
        tick(); applyStimulus(BLK_E, 1'b1, 4'd4); settle();
        expectBeat("one.m0", 32'hD0D1D2D3, 1'b1, 1'b1, 2'd0);
        checkOutput("one.m0.blk_ready", blk_ready, 1'b1);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("one.m1", 32'hE0E1E2E3, 1'b1, 1'b1, 2'd0);
        tick(); settle();
        checkOutput("one.after.valid", st_if.valid, 1'b0);

        // Backpressure: fields hold while stalled, four beats in order.
        tick(); applyStimulus(BLK_A, 1'b1, 4'd0);
        tick(); blk_valid = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                st_if.ready = (pat[c] != 0);
                settle();
                expectBeat($sformatf("bp.c%0d", c), wordsA[k], k == 0, k == 3, 2'd0);
                checkOutput($sformatf("bp.c%0d.blk_ready", c), blk_ready,
                            (k == 3) && st_if.ready);
                if (st_if.ready) begin
                    k++;
                end
                tick();
            end
        end
        st_if.ready = 1'b1; settle();
        checkOutput("bp.after.valid", st_if.valid, 1'b0);

        // Reset in the middle of a 4-beat non-final block.
        tick(); applyStimulus(BLK_B, 1'b0, 4'd0);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("mr.b0", 32'h10000001, 1'b1, 1'b0, 2'd0);
        tick(); settle();
        expectBeat("mr.b1", 32'h10000002, 1'b0, 1'b0, 2'd0);
        tick(); rst_n = 1'b0; settle();
        checkOutput("mr.rst.blk_ready", blk_ready, 1'b0);
        checkOutput("mr.rst.valid", st_if.valid, 1'b0);
        tick(); rst_n = 1'b1; settle();
        checkOutput("mr.post.valid", st_if.valid, 1'b0);
        checkOutput("mr.post.blk_ready", blk_ready, 1'b1);
        applyStimulus(BLK_C, 1'b1, 4'd0);
        tick(); blk_valid = 1'b0; settle();
        expectBeat("mr.new.b0", 32'h20000001, 1'b1, 1'b0, 2'd0);
        tick(); settle(); expectBeat("mr.new.b1", 32'h20000002, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("mr.new.b2", 32'h20000003, 1'b0, 1'b0, 2'd0);
        tick(); settle(); expectBeat("mr.new.b3", 32'h20000004, 1'b0, 1'b1, 2'd0);
        tick(); settle();
        checkOutput("mr.after.valid", st_if.valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
